// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit and its AXI4 master port.
package lsu_pkg;

    // Width of the AXI ID fields carried on the master interface.
    localparam int AXI_ID_W = 4;

    // Access size encodings. The value is log2 of the access width in bytes.
    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    // AXI burst type used for every access. Accesses are single-beat, so INCR is a formality.
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } mem_op_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_BUSERR   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lsu_err_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AWW  = 3'd3,
        B    = 3'd4,
        RESP = 3'd5
    } lsu_state_t;

    // An address is misaligned when any of its low log2(bytes) bits are set.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] low);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = low[0];
            SIZE_WORD: mis = |low[1:0];
            default:   mis = |low;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/axi4_interface.sv
// Single-clock AXI4 bundle. Only the fields needed by single-beat, fixed-ID traffic are carried.
interface axi4_interface #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import lsu_pkg::*;

    logic [AXI_ID_W-1:0]  awid;
    logic [ADDR_W-1:0]    awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awvalid;
    logic                 awready;

    logic [DATA_W-1:0]    wdata;
    logic [DATA_W/8-1:0]  wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [AXI_ID_W-1:0]  arid;
    logic [ADDR_W-1:0]    araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;

    logic [DATA_W-1:0]    rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering between a right-aligned core view and the AXI data bus:
// store strobe/data placement and load data extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES)
) (
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [LANES-1:0]  bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] load_data
);

    logic [LANES-1:0]  size_mask;
    logic [DATA_W-1:0] shifted;

    // Place store bytes on their lanes and bring load bytes down to bit 0, then extend.
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            size_mask[i] = (i < (1 << size));
        end

        bus_wstrb = size_mask << offset;
        bus_wdata = store_data << {offset, 3'b000};
        shifted   = bus_rdata >> {offset, 3'b000};

        case (size)
            SIZE_BYTE: load_data = is_unsigned ? DATA_W'(shifted[7:0])
                                               : DATA_W'($signed(shifted[7:0]));
            SIZE_HALF: load_data = is_unsigned ? DATA_W'(shifted[15:0])
                                               : DATA_W'($signed(shifted[15:0]));
            SIZE_WORD: load_data = is_unsigned ? DATA_W'(shifted[31:0])
                                               : DATA_W'($signed(shifted[31:0]));
            default:   load_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_axi.sv
// Load/store unit: accepts one memory request at a time, turns it into a single-beat
// AXI4 read or write, and returns extended load data plus a status code.
module lsu_axi
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int AXI_ID  = 0,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  mem_op_t           req_op,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output lsu_err_t          resp_err,
    axi4_interface.master     mem
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    lsu_state_t        state;
    lsu_state_t        state_next;
    logic [15:0]       wait_cnt;
    logic              wait_expired;
    logic              aw_done;
    logic              w_done;

    mem_op_t           op_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    lsu_err_t          err_next;
    logic              load_ok;
    logic [DATA_W-1:0] load_data;

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .offset      (addr_q[OFF_W-1:0]),
        .store_data  (wdata_q),
        .bus_rdata   (mem.rdata),
        .bus_wstrb   (mem.wstrb),
        .bus_wdata   (mem.wdata),
        .load_data   (load_data)
    );

    assign wait_expired = (wait_cnt == 16'(TIMEOUT - 1));

    assign mem.araddr  = addr_q;
    assign mem.arsize  = {1'b0, size_q};
    assign mem.arlen   = 8'd0;
    assign mem.arburst = AXI_BURST_INCR;
    assign mem.arid    = AXI_ID_W'(AXI_ID);
    assign mem.awaddr  = addr_q;
    assign mem.awsize  = {1'b0, size_q};
    assign mem.awlen   = 8'd0;
    assign mem.awburst = AXI_BURST_INCR;
    assign mem.awid    = AXI_ID_W'(AXI_ID);
    assign mem.wlast   = 1'b1;

    // State register; reset drops straight to IDLE so every valid/ready output falls at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, channel handshake outputs and the status to record on entry to RESP.
    always_comb begin
        state_next  = state;
        err_next    = ERR_OK;
        load_ok     = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awvalid = 1'b0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (is_misaligned(req_size, req_addr[2:0])) begin
                        state_next = RESP;
                        err_next   = ERR_MISALIGN;
                    end else if (req_op == OP_LOAD) begin
                        state_next = AR;
                    end else begin
                        state_next = AWW;
                    end
                end
            end
            AR: begin
                mem.arvalid = 1'b1;
                if (mem.arready) begin
                    state_next = R;
                end else if (wait_expired) begin
                    state_next = RESP;
                    err_next   = ERR_TIMEOUT;
                end
            end
            R: begin
                mem.rready = 1'b1;
                if (mem.rvalid) begin
                    state_next = RESP;
                    if (mem.rresp != 2'b00) begin
                        err_next = ERR_BUSERR;
                    end else begin
                        load_ok = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_next = RESP;
                    err_next   = ERR_TIMEOUT;
                end
            end
            AWW: begin
                mem.awvalid = !aw_done;
                mem.wvalid  = !w_done;
                if ((aw_done || mem.awready) && (w_done || mem.wready)) begin
                    state_next = B;
                end else if (wait_expired) begin
                    state_next = RESP;
                    err_next   = ERR_TIMEOUT;
                end
            end
            B: begin
                mem.bready = 1'b1;
                if (mem.bvalid) begin
                    state_next = RESP;
                    err_next   = (mem.bresp != 2'b00) ? ERR_BUSERR : ERR_OK;
                end else if (wait_expired) begin
                    state_next = RESP;
                    err_next   = ERR_TIMEOUT;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, write-channel completion flags, channel wait counter and the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_LOAD;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            wait_cnt   <= '0;
            resp_err   <= ERR_OK;
            resp_rdata <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q       <= req_op;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end

            if (state == AWW) begin
                if (mem.awvalid && mem.awready) begin
                    aw_done <= 1'b1;
                end
                if (mem.wvalid && mem.wready) begin
                    w_done <= 1'b1;
                end
            end

            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state inside {AR, R, AWW, B}) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            if (state != RESP && state_next == RESP) begin
                resp_err   <= err_next;
                resp_rdata <= load_ok ? load_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_axi.sv
// Self-checking bench for lsu_axi: a scripted AXI slave answers each access, expected
// completions are queued when a request is issued and compared when the LSU hands them back.
module tb_lsu_axi;
    import lsu_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int AXI_ID  = 5;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    mem_op_t           req_op;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    lsu_err_t          resp_err;

    axi4_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    lsu_axi #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .AXI_ID  (AXI_ID),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        lsu_err_t          err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   ar_hs = 0;
    int   aw_hs = 0;
    int   w_hs = 0;
    int   ar_cycles = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count handshakes and cycles with arvalid high so traffic volume can be checked.
    always @(posedge clk) begin
        if (mem_if.arvalid && mem_if.arready) ar_hs <= ar_hs + 1;
        if (mem_if.awvalid && mem_if.awready) aw_hs <= aw_hs + 1;
        if (mem_if.wvalid && mem_if.wready)   w_hs  <= w_hs + 1;
        if (mem_if.arvalid)                   ar_cycles <= ar_cycles + 1;
    end

    // Pop the oldest expected completion whenever the LSU hands one over.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
                checkOutput("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    task automatic applyStimulus(input mem_op_t op, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input lsu_err_t exp_err);
        exp_t e;
        int   n;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        req_op       = op;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) checkOutput("req_accept_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
        checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    task automatic serveRead(input int ar_wait, input int r_wait, input logic [31:0] exp_addr,
                             input logic [2:0] exp_size, input logic [31:0] rdata,
                             input logic [1:0] rresp, input bit respond);
        int n;
        n = 0;
        while (!mem_if.arvalid && n < 50) begin
            tick();
            n++;
        end
        if (!mem_if.arvalid) begin
            checkOutput("arvalid_timeout", 64'd0, 64'd1);
            return;
        end
        repeat (ar_wait) tick();
        checkOutput("arvalid_held", 64'(mem_if.arvalid), 64'd1);
        checkOutput("araddr", 64'(mem_if.araddr), 64'(exp_addr));
        checkOutput("arsize", 64'(mem_if.arsize), 64'(exp_size));
        checkOutput("arlen", 64'(mem_if.arlen), 64'd0);
        checkOutput("arburst", 64'(mem_if.arburst), 64'd1);
        checkOutput("arid", 64'(mem_if.arid), 64'(AXI_ID));
        mem_if.arready = 1'b1;
        tick();
        mem_if.arready = 1'b0;
        if (!respond) return;
        repeat (r_wait) tick();
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = rdata;
        mem_if.rresp  = rresp;
        n = 0;
        while (!mem_if.rready && n < 50) begin
            tick();
            n++;
        end
        if (!mem_if.rready) checkOutput("rready_timeout", 64'd0, 64'd1);
        tick();
        mem_if.rvalid = 1'b0;
    endtask

    task automatic serveWrite(input int aw_wait, input int w_wait, input logic [31:0] exp_addr,
                              input logic [2:0] exp_size, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input logic [1:0] bresp);
        int n;
        fork
            begin : aw_side
                int k;
                k = 0;
                while (!mem_if.awvalid && k < 50) begin
                    tick();
                    k++;
                end
                repeat (aw_wait) tick();
                checkOutput("awaddr", 64'(mem_if.awaddr), 64'(exp_addr));
                checkOutput("awsize", 64'(mem_if.awsize), 64'(exp_size));
                checkOutput("awlen_burst_id", 64'({mem_if.awlen, mem_if.awburst, mem_if.awid}),
                            64'({8'd0, 2'b01, 4'(AXI_ID)}));
                mem_if.awready = 1'b1;
                tick();
                mem_if.awready = 1'b0;
                checkOutput("awvalid_drop", 64'(mem_if.awvalid), 64'd0);
            end
            begin : w_side
                int k;
                k = 0;
                while (!mem_if.wvalid && k < 50) begin
                    tick();
                    k++;
                end
                repeat (w_wait) tick();
                checkOutput("wstrb", 64'(mem_if.wstrb), 64'(exp_strb));
                checkOutput("wdata", 64'(mem_if.wdata), 64'(exp_wdata));
                checkOutput("wlast", 64'(mem_if.wlast), 64'd1);
                mem_if.wready = 1'b1;
                tick();
                mem_if.wready = 1'b0;
                checkOutput("wvalid_drop", 64'(mem_if.wvalid), 64'd0);
            end
        join
        mem_if.bvalid = 1'b1;
        mem_if.bresp  = bresp;
        n = 0;
        while (!mem_if.bready && n < 50) begin
            tick();
            n++;
        end
        if (!mem_if.bready) checkOutput("bready_timeout", 64'd0, 64'd1);
        tick();
        mem_if.bvalid = 1'b0;
        mem_if.bresp  = 2'b00;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("sb_drain", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        tick();
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int ar_before;
        int aw_before;
        int w_before;

        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_op         = OP_LOAD;
        req_size       = SIZE_BYTE;
        req_unsigned   = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        resp_ready     = 1'b1;
        mem_if.arready = 1'b0;
        mem_if.rvalid  = 1'b0;
        mem_if.rdata   = '0;
        mem_if.rresp   = 2'b00;
        mem_if.awready = 1'b0;
        mem_if.wready  = 1'b0;
        mem_if.bvalid  = 1'b0;
        mem_if.bresp   = 2'b00;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset_resp_err", 64'(resp_err), 64'(ERR_OK));
        checkOutput("reset_axi_valids", 64'({mem_if.arvalid, mem_if.awvalid, mem_if.wvalid,
                                             mem_if.rready, mem_if.bready}), 64'd0);
        tick();

        $display("[TB] signed byte load, delayed arready");
        fork
            applyStimulus(OP_LOAD, SIZE_BYTE, 1'b0, 32'h1003, 32'h0, 32'hFFFF_FF80, ERR_OK);
            serveRead(3, 1, 32'h1003, 3'd0, 32'h80FF_FFFF, 2'b00, 1'b1);
        join
        waitDrain();

        $display("[TB] half and word loads");
        fork
            applyStimulus(OP_LOAD, SIZE_HALF, 1'b1, 32'h5002, 32'h0, 32'h0000_8001, ERR_OK);
            serveRead(0, 2, 32'h5002, 3'd1, 32'h8001_0000, 2'b00, 1'b1);
        join
        waitDrain();
        fork
            applyStimulus(OP_LOAD, SIZE_HALF, 1'b0, 32'h5000, 32'h0, 32'hFFFF_F00D, ERR_OK);
            serveRead(1, 0, 32'h5000, 3'd1, 32'h1234_F00D, 2'b00, 1'b1);
        join
        waitDrain();
        fork
            applyStimulus(OP_LOAD, SIZE_WORD, 1'b0, 32'h5004, 32'h0, 32'hDEAD_BEEF, ERR_OK);
            serveRead(0, 0, 32'h5004, 3'd2, 32'hDEAD_BEEF, 2'b00, 1'b1);
        join
        waitDrain();
        fork
            applyStimulus(OP_LOAD, SIZE_WORD, 1'b0, 32'h5008, 32'h0, 32'h0, ERR_BUSERR);
            serveRead(0, 1, 32'h5008, 3'd2, 32'h1234_5678, 2'b11, 1'b1);
        join
        waitDrain();

        $display("[TB] half store, aw and w ready in different cycles");
        aw_before = aw_hs;
        w_before  = w_hs;
        fork
            applyStimulus(OP_STORE, SIZE_HALF, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0, ERR_OK);
            serveWrite(1, 3, 32'h2002, 3'd1, 4'b1100, 32'hBEEF_0000, 2'b00);
        join
        waitDrain();
        checkOutput("aw_handshakes", 64'(aw_hs - aw_before), 64'd1);
        checkOutput("w_handshakes", 64'(w_hs - w_before), 64'd1);

        $display("[TB] word store with same-cycle handshakes, byte store");
        fork
            applyStimulus(OP_STORE, SIZE_WORD, 1'b0, 32'h2000, 32'h1234_5678, 32'h0, ERR_OK);
            serveWrite(0, 0, 32'h2000, 3'd2, 4'b1111, 32'h1234_5678, 2'b00);
        join
        waitDrain();
        fork
            applyStimulus(OP_STORE, SIZE_BYTE, 1'b0, 32'h2001, 32'h0000_00A5, 32'h0, ERR_OK);
            serveWrite(2, 0, 32'h2001, 3'd0, 4'b0010, 32'h0000_A500, 2'b00);
        join
        waitDrain();

        $display("[TB] misaligned accesses");
        ar_before = ar_cycles;
        applyStimulus(OP_LOAD, SIZE_WORD, 1'b0, 32'h3001, 32'h0, 32'h0, ERR_MISALIGN);
        checkOutput("misalign_resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("misalign_resp_err", 64'(resp_err), 64'(ERR_MISALIGN));
        waitDrain();
        checkOutput("misalign_no_arvalid", 64'(ar_cycles - ar_before), 64'd0);
        aw_before = aw_hs;
        applyStimulus(OP_STORE, SIZE_HALF, 1'b0, 32'h2001, 32'h1111, 32'h0, ERR_MISALIGN);
        waitDrain();
        checkOutput("misalign_no_aw", 64'(aw_hs - aw_before), 64'd0);

        $display("[TB] store bus error with stalled consumer");
        resp_ready = 1'b0;
        fork
            applyStimulus(OP_STORE, SIZE_WORD, 1'b0, 32'h2004, 32'hCAFE_F00D, 32'h0, ERR_BUSERR);
            serveWrite(0, 1, 32'h2004, 3'd2, 4'b1111, 32'hCAFE_F00D, 2'b10);
        join
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("stall_resp_err", 64'(resp_err), 64'(ERR_BUSERR));
            checkOutput("stall_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        waitDrain();

        $display("[TB] read data never returned");
        fork
            applyStimulus(OP_LOAD, SIZE_WORD, 1'b0, 32'h4000, 32'h0, 32'h0, ERR_TIMEOUT);
            serveRead(0, 0, 32'h4000, 3'd2, 32'h0, 2'b00, 1'b0);
        join
        repeat (TIMEOUT - 1) tick();
        checkOutput("timeout_rready_before", 64'(mem_if.rready), 64'd1);
        tick();
        checkOutput("timeout_rready_after", 64'(mem_if.rready), 64'd0);
        checkOutput("timeout_resp_err", 64'(resp_err), 64'(ERR_TIMEOUT));
        waitDrain();
        mem_if.rvalid = 1'b1;
        mem_if.rdata  = 32'h5555_5555;
        tick();
        checkOutput("late_rvalid_ignored", 64'(mem_if.rready), 64'd0);
        tick();
        mem_if.rvalid = 1'b0;

        $display("[TB] reset during write address/data phase");
        applyStimulus(OP_STORE, SIZE_WORD, 1'b0, 32'h6000, 32'h0BAD_0BAD, 32'h0, ERR_OK);
        checkOutput("aww_awvalid", 64'(mem_if.awvalid), 64'd1);
        checkOutput("aww_wvalid", 64'(mem_if.wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_awvalid", 64'(mem_if.awvalid), 64'd0);
        checkOutput("rst_wvalid", 64'(mem_if.wvalid), 64'd0);
        checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req_ready", 64'(req_ready), 64'd1);
        checkOutput("post_rst_resp_err", 64'(resp_err), 64'(ERR_OK));
        tick();

        fork
            applyStimulus(OP_LOAD, SIZE_BYTE, 1'b1, 32'h7001, 32'h0, 32'h0000_00AB, ERR_OK);
            serveRead(0, 0, 32'h7001, 3'd0, 32'h0000_AB00, 2'b00, 1'b1);
        join
        waitDrain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
